// File: rtl/md_scheduler.sv
// Multiply/divide controller: owns HI/LO, runs the fixed busy window
// and raises the D-stage stall that keeps a second MD op out of E.
module md_scheduler #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       E_MDop,
  input  logic [WIDTH-1:0] E_A,
  input  logic [WIDTH-1:0] E_B,
  input  logic             D_md_use,
  output logic [WIDTH-1:0] E_MD_out,
  output logic             md_busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] phi_q;
  logic [WIDTH-1:0] plo_q;
  logic             pwr_q;
  logic             busy_q;

  logic op_mult;
  logic op_multu;
  logic op_div;
  logic op_divu;
  logic op_mthi;
  logic op_mtlo;
  logic op_mfhi;
  logic op_mflo;
  logic e_start;
  logic is_div;
  logic sgn;
  logic div0;

  assign op_mult  = (E_MDop == 4'd1);
  assign op_multu = (E_MDop == 4'd2);
  assign op_div   = (E_MDop == 4'd3);
  assign op_divu  = (E_MDop == 4'd4);
  assign op_mthi  = (E_MDop == 4'd5);
  assign op_mtlo  = (E_MDop == 4'd6);
  assign op_mfhi  = (E_MDop == 4'd7);
  assign op_mflo  = (E_MDop == 4'd8);

  assign e_start = op_mult | op_multu
                 | op_div | op_divu;
  assign is_div  = op_div | op_divu;
  assign sgn     = op_mult | op_div;
  assign div0    = (E_B == '0);

  // One multiplier: the low 2W bits of a product of
  // extended operands serve both signed and unsigned.
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  assign a_ext = {{WIDTH{sgn & E_A[WIDTH-1]}}, E_A};
  assign b_ext = {{WIDTH{sgn & E_B[WIDTH-1]}}, E_B};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes and fix signs afterwards; this
  // also yields MIN / -1 = MIN with remainder 0.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dr;

  assign a_neg  = sgn & E_A[WIDTH-1];
  assign b_neg  = sgn & E_B[WIDTH-1];
  assign a_mag  = a_neg ? (~E_A + 1'b1) : E_A;
  assign b_mag  = b_neg ? (~E_B + 1'b1) : E_B;
  assign b_safe = div0 ? {{(WIDTH-1){1'b0}}, 1'b1}
                       : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;
  assign dq     = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
  assign dr     = a_neg ? (~ur + 1'b1) : ur;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign res_hi = is_div ? dr : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? dq : prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (e_start) begin
            phi_q   <= res_hi;
            plo_q   <= res_lo;
            pwr_q   <= ~(is_div & div0);
            cnt_q   <= is_div ? DC : MC;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (op_mthi) begin
            hi_q <= E_A;
          end else if (op_mtlo) begin
            lo_q <= E_A;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
            pwr_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    E_MD_out = '0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        op_mfhi: E_MD_out = hi_q;
        op_mflo: E_MD_out = lo_q;
        default: E_MD_out = '0;
      endcase
    end
  end

  assign md_busy  = busy_q;
  assign md_stall = D_md_use & (busy_q | e_start);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed scenarios plus random
// traffic checked against a cycle-timestamp reference model.
module tb_md_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic [31:0] E_MD_out;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  md_scheduler #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .E_MDop(E_MDop),
    .E_A(E_A),
    .E_B(E_B),
    .D_md_use(D_md_use),
    .E_MD_out(E_MD_out),
    .md_busy(md_busy),
    .md_stall(md_stall),
    .HI(HI),
    .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  // Reference model: results become visible at commit_at.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwr;
  int          commit_at = -1;
  int          cyc = 0;

  function automatic bit m_busy();
    return (commit_at >= 0) && (cyc < commit_at);
  endfunction

  task automatic m_launch(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_pwr = 1'b1;
    case (op)
      4'd1: begin
        p = sa * sb;
        m_phi = p[63:32];
        m_plo = p[31:0];
      end
      4'd2: begin
        pu = {32'b0, a} * {32'b0, b};
        m_phi = pu[63:32];
        m_plo = pu[31:0];
      end
      4'd3: begin
        if (b == 0) m_pwr = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          m_phi = r[31:0];
          m_plo = q[31:0];
        end
      end
      default: begin
        if (b == 0) m_pwr = 1'b0;
        else begin
          m_phi = a % b;
          m_plo = a / b;
        end
      end
    endcase
    commit_at = cyc + 1 + ((op <= 4'd2) ? 5 : 10);
  endtask

  task automatic step(input logic [3:0]  op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic        du,
                      input logic        rs);
    bit          bz;
    logic [31:0] eo;
    E_MDop   = op;
    E_A      = a;
    E_B      = b;
    D_md_use = du;
    reset    = rs;
    if (commit_at == cyc) begin
      if (m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
      commit_at = -1;
    end
    bz = m_busy();
    eo = 32'h0;
    if (!bz && op == 4'd7) eo = m_hi;
    if (!bz && op == 4'd8) eo = m_lo;
    #3;
    chk("busy", {31'b0, md_busy}, {31'b0, bz});
    chk("stall", {31'b0, md_stall},
        {31'b0, du && (bz || (op >= 4'd1 && op <= 4'd4))});
    chk("md_out", E_MD_out, eo);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    if (rs) begin
      m_hi = 0;
      m_lo = 0;
      commit_at = -1;
    end else if (!bz) begin
      if (op >= 4'd1 && op <= 4'd4) m_launch(op, a, b);
      else if (op == 4'd5) m_hi = a;
      else if (op == 4'd6) m_lo = a;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic du);
    for (int i = 0; i < n; i++) step(4'd0, 0, 0, du, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0;
    E_MDop = 0; E_A = 0; E_B = 0; D_md_use = 0; reset = 1;
    @(posedge clk);
    #1;
    // Reset held two cycles.
    step(4'd0, 0, 0, 1'b0, 1'b1);
    step(4'd0, 0, 0, 1'b0, 1'b1);
    chk("rst_hi", HI, 32'h0);
    chk("rst_busy", {31'b0, md_busy}, 32'h0);

    // Mult aborted by reset at busy cycle 3.
    step(4'd1, 7, 6, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(4'd0, 0, 0, 1'b0, 1'b1);
    chk("abort_busy", {31'b0, md_busy}, 32'h0);
    idle(8, 1'b0);
    chk("abort_lo", LO, 32'h0);

    // Signed mult with mflo stalled behind it.
    step(4'd1, 32'hFFFF_FFFE, 3, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(4'd8, 0, 0, 1'b0, 1'b0);
    chk("mflo_new", E_MD_out, 32'hFFFF_FFFA);
    chk("mult_hi", HI, 32'hFFFF_FFFF);

    step(4'd2, 32'hFFFF_FFFE, 3, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("multu_hi", HI, 32'h2);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    step(4'd3, 32'hFFFF_FFF9, 2, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    step(4'd4, 7, 2, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("divu_lo", LO, 32'h3);
    chk("divu_hi", HI, 32'h1);

    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0);

    // Divide by zero leaves HI/LO alone.
    step(4'd5, 32'h11, 0, 1'b0, 1'b0);
    step(4'd6, 32'h22, 0, 1'b0, 1'b0);
    step(4'd4, 5, 0, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("dz_hi", HI, 32'h11);
    chk("dz_lo", LO, 32'h22);

    step(4'd6, 32'hABCD, 0, 1'b0, 1'b0);
    step(4'd8, 0, 0, 1'b0, 1'b0);
    chk("mtlo_rd", E_MD_out, 32'hABCD);

    for (int op = 9; op < 16; op++)
      step(4'(op), $urandom, $urandom, 1'b0, 1'b0);
    chk("nop_lo", LO, 32'hABCD);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      if (m_busy() && $urandom_range(0, 9) != 0) op = 4'd0;
      else op = 4'($urandom_range(0, 15));
      step(op, pick(), pick(), 1'($urandom),
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
